// File: rtl/alu_multiword_sequencer.sv
// alu_multiword_sequencer: runs a WORDS x 16-bit operation on a 16-bit combinational ALU one word per clock, chaining carry and folding flags
module alu_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [2:0]          OP,
  input  logic [16*WORDS-1:0] A_IN,
  input  logic [16*WORDS-1:0] B_IN,
  input  logic                CIN_IN,
  output logic                BUSY,
  output logic                DONE,
  output logic [16*WORDS-1:0] RESULT,
  output logic                C_OUT,
  output logic                Z_OUT,
  output logic                S_OUT,
  output logic                V_OUT,
  output logic [3:0]          ALU_FSEL,
  output logic [15:0]         ALU_ABUS,
  output logic [15:0]         ALU_BBUS,
  output logic                ALU_CIN,
  input  logic [15:0]         ALU_FOUT,
  input  logic                ALU_C,
  input  logic                ALU_Z,
  input  logic                ALU_S,
  input  logic                ALU_V
);
  localparam int W = 16 * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SHL = 3'd2, SHR = 3'd3, ASR = 3'd4, RLC = 3'd5, RRC = 3'd6, MOV = 3'd7;
  logic [1:0] st;
  logic [CW-1:0] cnt, idx;
  logic [2:0] op_r;
  logic [W-1:0] a_r, b_r, wrk, wrk_nxt;
  logic cy, zacc, s_r, v_r, run, first, msw_first, msw_now, arith, cin_used;
  assign run = st == RUN;
  assign first = cnt == '0;
  assign msw_first = op_r == SHR || op_r == ASR || op_r == RRC;
  assign idx = msw_first ? LAST - cnt : cnt;
  assign msw_now = idx == LAST;
  assign arith = op_r == ADD || op_r == SUB;
  assign cin_used = arith || op_r == RLC || op_r == RRC;
  assign BUSY = st != IDLE;
  assign DONE = st == FIN;
  assign ALU_ABUS = run ? a_r[idx*16 +: 16] : 16'h0;
  assign ALU_BBUS = run && arith ? b_r[idx*16 +: 16] : 16'h0;
  assign ALU_CIN = run && (first ? cin_used && cy : cy);
  always_comb begin
    ALU_FSEL = !run        ? 4'b0000 :
               op_r == ADD ? 4'b0011 :
               op_r == SUB ? 4'b0100 :
               op_r == SHL ? (first ? 4'b1001 : 4'b1100) :
               op_r == SHR ? (first ? 4'b1010 : 4'b1101) :
               op_r == ASR ? (first ? 4'b1011 : 4'b1101) :
               op_r == RLC ? 4'b1100 :
               op_r == RRC ? 4'b1101 : 4'b0000;
  end
  always_comb begin
    wrk_nxt = wrk;
    wrk_nxt[idx*16 +: 16] = ALU_FOUT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= IDLE;
      cnt <= '0;
      op_r <= ADD;
      a_r <= '0;
      b_r <= '0;
      wrk <= '0;
      cy <= 1'b0;
      zacc <= 1'b0;
      s_r <= 1'b0;
      v_r <= 1'b0;
      RESULT <= '0;
      C_OUT <= 1'b0;
      Z_OUT <= 1'b0;
      S_OUT <= 1'b0;
      V_OUT <= 1'b0;
    end else begin
      case (st)
        IDLE: if (START) begin
          a_r <= A_IN;
          b_r <= B_IN;
          op_r <= OP;
          cy <= CIN_IN;
          cnt <= '0;
          zacc <= 1'b1;
          st <= RUN;
        end
        RUN: begin
          wrk <= wrk_nxt;
          cy <= ALU_C;
          zacc <= zacc & ALU_Z;
          cnt <= cnt + 1'b1;
          if (msw_now) begin
            s_r <= ALU_S;
            v_r <= ALU_V;
          end
          if (cnt == LAST) begin
            st <= FIN;
            RESULT <= wrk_nxt;
            C_OUT <= op_r != MOV && ALU_C;
            Z_OUT <= zacc & ALU_Z;
            S_OUT <= msw_now ? ALU_S : s_r;
            V_OUT <= arith && (msw_now ? ALU_V : v_r);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// tb_alu_multiword_sequencer: directed vector check of the multiword sequencer against a 16-bit ALU model
module tb_alu_multiword_sequencer;
  typedef struct {
    logic [2:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic cin;
    logic [63:0] res;
    logic c;
    logic z;
    logic s;
    logic v;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [2:0] op = 3'd0;
  logic [63:0] a = '0, b = '0;
  logic busy, done, c_out, z_out, s_out, v_out;
  logic [63:0] result;
  logic [3:0] alu_fsel;
  logic [15:0] alu_a, alu_b, alu_f;
  logic alu_cin, alu_c, alu_z, alu_s, alu_v;
  logic [16:0] t;
  int checks = 0, errors = 0;
  vec_t tv[11];
  always #5 clk = ~clk;
  alu_multiword_sequencer #(.WORDS(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .OP(op), .A_IN(a), .B_IN(b), .CIN_IN(cin),
    .BUSY(busy), .DONE(done), .RESULT(result),
    .C_OUT(c_out), .Z_OUT(z_out), .S_OUT(s_out), .V_OUT(v_out),
    .ALU_FSEL(alu_fsel), .ALU_ABUS(alu_a), .ALU_BBUS(alu_b), .ALU_CIN(alu_cin),
    .ALU_FOUT(alu_f), .ALU_C(alu_c), .ALU_Z(alu_z), .ALU_S(alu_s), .ALU_V(alu_v)
  );
  always_comb begin
    t = '0;
    alu_f = alu_a;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_fsel)
      4'b0011: begin
        t = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
        alu_f = t[15:0];
        alu_c = t[16];
        alu_v = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
      end
      4'b0100: begin
        t = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_cin);
        alu_f = t[15:0];
        alu_c = t[16];
        alu_v = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
      end
      4'b1001: begin alu_f = {alu_a[14:0], 1'b0}; alu_c = alu_a[15]; end
      4'b1010: begin alu_f = {1'b0, alu_a[15:1]}; alu_c = alu_a[0]; end
      4'b1011: begin alu_f = {alu_a[15], alu_a[15:1]}; alu_c = alu_a[0]; end
      4'b1100: begin alu_f = {alu_a[14:0], alu_cin}; alu_c = alu_a[15]; end
      4'b1101: begin alu_f = {alu_cin, alu_a[15:1]}; alu_c = alu_a[0]; end
      default: alu_f = alu_a;
    endcase
    alu_z = alu_f == 16'h0;
    alu_s = alu_f[15];
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_flags(input int n, input vec_t v);
    chk($sformatf("v%0d result", n), result, v.res);
    chk($sformatf("v%0d C", n), 64'(c_out), 64'(v.c));
    chk($sformatf("v%0d Z", n), 64'(z_out), 64'(v.z));
    chk($sformatf("v%0d S", n), 64'(s_out), 64'(v.s));
    chk($sformatf("v%0d V", n), 64'(v_out), 64'(v.v));
  endtask
  task automatic run_op(input int n, input vec_t v);
    int lat;
    logic bb;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bb = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== 1'b1) bb = 1'b1;
      if (done === 1'b1) lat = k;
    end
    chk($sformatf("v%0d latency", n), 64'(lat), 64'd5);
    chk($sformatf("v%0d busy", n), 64'(bb), 64'd0);
    chk_flags(n, v);
  endtask
  initial begin
    int dn, lat;
    tv[0]  = '{3'd0, 64'h00000000FFFFFFFF, 64'h1, 1'b0, 64'h0000000100000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{3'd0, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[2]  = '{3'd1, 64'h0, 64'h1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{3'd1, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{3'd4, 64'h8000000000000001, 64'h0, 1'b0, 64'hC000000000000000, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{3'd3, 64'h8000000000000001, 64'h0, 1'b0, 64'h4000000000000000, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{3'd2, 64'h8000000000000001, 64'h0, 1'b0, 64'h0000000000000002, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{3'd5, 64'h8000000000000001, 64'h0, 1'b1, 64'h0000000000000003, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{3'd7, 64'hF000000000000000, 64'h5555, 1'b1, 64'hF000000000000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{3'd6, 64'h0000000000000002, 64'h0, 1'b1, 64'h8000000000000001, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{3'd7, 64'h0, 64'hFFFF, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'h0);
    chk("reset flags", 64'({c_out, z_out, s_out, v_out}), 64'd0);
    chk("reset alu", {27'h0, alu_fsel, alu_a, alu_b, alu_cin}, 64'h0);
    for (int i = 0; i < 11; i++) run_op(i, tv[i]);
    @(negedge clk);
    op = tv[0].op; a = tv[0].a; b = tv[0].b; cin = tv[0].cin; start = 1'b1;
    dn = 0;
    lat = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = k == 2;
      if (k == 2) begin op = 3'd1; a = 64'h5; b = 64'h5; end
      if (done === 1'b1) begin dn++; if (dn == 1) lat = k; end
    end
    chk("ignored start dones", 64'(dn), 64'd1);
    chk("ignored start latency", 64'(lat), 64'd5);
    chk("ignored start result", result, tv[0].res);
    @(negedge clk);
    op = tv[1].op; a = tv[1].a; b = tv[1].b; cin = tv[1].cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result", result, 64'h0);
    chk("abort done", 64'(done), 64'd0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort no done", 64'(dn), 64'd0);
    run_op(3, tv[3]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_multiword_sequencer.md
Name: alu_multiword_sequencer

Overview:
- Initiator-side controller for the 16-bit combinational ALU (FSEL/ABUS/BBUS/CIN in; FOUT/C/Z/S/V out).
- Executes one WORDS×16-bit add, subtract, shift, rotate or move as a sequence of single-word ALU operations, one word per clock.
- Chains carry/borrow word to word and folds the per-word flags into whole-operand flags.
- Sits between the datapath control FSM and the ALU instance.

Parameters:
- WORDS, 4, number of 16-bit words per operand (≥2); operand width W = 16*WORDS.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE
- OP  in  3  0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 ASR, 5 RLC, 6 RRC, 7 MOV
- A_IN  in  W  operand A, latched on accepted START
- B_IN  in  W  operand B, latched on accepted START
- CIN_IN  in  1  initial carry/borrow, latched on accepted START
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse
- RESULT  out  W  final result, held until the next accepted START
- C_OUT, Z_OUT, S_OUT, V_OUT  out  1 each  whole-operand flags, held with RESULT
- ALU_FSEL  out  4  to ALU FSEL
- ALU_ABUS, ALU_BBUS  out  16  to ALU operand buses
- ALU_CIN  out  1  to ALU CIN
- ALU_FOUT  in  16  from ALU
- ALU_C, ALU_Z, ALU_S, ALU_V  in  1 each  from ALU

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - BUSY, DONE, RESULT and all flags go to 0.
  - ALU outputs go to FSEL=0000, buses 0, CIN 0.
  - Reset asserted mid-operation aborts the operation; no DONE is produced.
- States: IDLE, RUN, FIN.
  - IDLE: on START=1, latch A_IN, B_IN, OP, CIN_IN; clear the step counter, set zacc=1, go to RUN.
  - RUN: step i (0..WORDS-1) lasts one cycle. The ALU is combinational, so the word's FOUT and flags are captured at the end of the same cycle. After step WORDS-1, go to FIN.
  - FIN: DONE=1 for exactly one cycle, then IDLE.
- BUSY is 1 in RUN and FIN. Latency: START edge to DONE is WORDS+1 cycles. Back-to-back START is accepted in the first IDLE cycle after FIN.
- START while BUSY is ignored and does not disturb the latched operands.
- In IDLE and FIN the ALU is driven FSEL=0000, buses 0, CIN 0.
- Word order:
  - LSW first: ADD, SUB, SHL, RLC, MOV.
  - MSW first: SHR, ASR, RRC.
- FSEL per step:
  - ADD 0011 every word.
  - SUB 0100 every word; ALU C is the borrow.
  - SHL: 1001 on the first word, 1100 on later words.
  - SHR: 1010 on the first word, 1101 on later words.
  - ASR: 1011 on the first word, 1101 on later words.
  - RLC 1100 every word.
  - RRC 1101 every word.
  - MOV 0000 every word.
- ALU_CIN on step 0:
  - CIN_IN for ADD, SUB, RLC and RRC.
  - 0 for SHL, SHR, ASR and MOV.
  - On every later step it is the ALU_C captured from the previous step.
- ALU_ABUS is word i of A in the processing order. ALU_BBUS is word i of B for ADD/SUB, 0 otherwise.
- Flag folding:
  - Z_OUT = AND of ALU_Z over all words.
  - C_OUT = ALU_C of the last step (0 for MOV).
  - S_OUT = ALU_S of the MSW step.
  - V_OUT = ALU_V of the MSW step for ADD/SUB, 0 otherwise.
- RESULT, C_OUT, Z_OUT, S_OUT and V_OUT update together at the edge entering FIN. They are stable while DONE=1 and until the next accepted START.
- Arithmetic is modulo 2^W; no saturation.

Test Plan (WORDS=4):
- ADD: A=0x00000000FFFFFFFF, B=1, CIN_IN=0.
  - RESULT=0x0000000100000000; C=0, Z=0, S=0, V=0.
  - DONE exactly 5 cycles after START; BUSY high for cycles 1–5.
- ADD overflow: A=0x7FFFFFFFFFFFFFFF, B=1.
  - RESULT=0x8000000000000000; V=1, S=1, C=0.
- SUB: A=0, B=1, CIN_IN=0.
  - RESULT=0xFFFFFFFFFFFFFFFF; C=1, S=1, Z=0, V=0.
  - Then SUB with A=B=0x123456789ABCDEF0: RESULT=0, Z=1, C=0.
- Shifts on A=0x8000000000000001:
  - ASR: RESULT=0xC000000000000000, C=1.
  - SHR: RESULT=0x4000000000000000, C=1.
  - SHL: RESULT=0x0000000000000002, C=1.
  - RLC with CIN_IN=1: RESULT=0x0000000000000003, C=1.
- START pulsed again during RUN with different operands -> ignored; the first result is unchanged and only one DONE is produced.
- RST asserted in the second RUN cycle -> next cycle BUSY=0, RESULT=0, no DONE; a new START then completes normally.
